// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit core: FSM states, line-control
// encodings, the divisor floor and the parity helper.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam logic [1:0] PS_ODD    = 2'b00;
  localparam logic [1:0] PS_EVEN   = 2'b01;
  localparam logic [1:0] PS_STICK1 = 2'b10;
  localparam logic [1:0] PS_STICK0 = 2'b11;

  localparam int unsigned MIN_DIV = 2;

  function automatic logic [7:0] wls_mask(input logic [1:0] wls);
    logic [7:0] mask;
    case (wls)
      WLS_5:   mask = 8'h1f;
      WLS_6:   mask = 8'h3f;
      WLS_7:   mask = 8'h7f;
      default: mask = 8'hff;
    endcase
    return mask;
  endfunction

  // Only the bits that will actually be sent contribute to the parity.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic [1:0] wls,
                                      input logic [1:0] ps);
    logic x;
    logic p;
    x = ^(data & wls_mask(wls));
    case (ps)
      PS_ODD:    p = ~x;
      PS_EVEN:   p = x;
      PS_STICK1: p = 1'b1;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: reloads to div_i-1 on restart or expiry and flags a tick
// on the last cycle of each period.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 restart_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (restart_i || (cnt_q == '0)) begin
      cnt_q <= div_i - DIV_WIDTH'(1);
    end else begin
      cnt_q <= cnt_q - DIV_WIDTH'(1);
    end
  end

  assign tick_o = (cnt_q == '0) && !restart_i;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit framer: start, 5-8 data bits LSB first, optional parity, 1-2 stops.
// Optional break control is compiled in with UART_TX_BREAK_EN.
module uart_tx_core
  import uart_tx_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [1:0]           wls_i,
  input  logic                 stb_i,
  input  logic                 pen_i,
  input  logic [1:0]           ps_i,
  input  logic                 tx_valid_i,
  input  logic [7:0]           tx_data_i,
  output logic                 tx_ready_o,
  output logic                 uart_tx_o,
  output logic                 busy_o,
  output logic                 done_o
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                 brk_i
`endif
);

  localparam logic [DIV_WIDTH-1:0] MIN_DIV_W = DIV_WIDTH'(MIN_DIV);

  tx_state_t            state_q;
  logic [7:0]           shift_q;
  logic [2:0]           bit_cnt_q;
  logic [1:0]           wls_q;
  logic                 stb_q;
  logic                 pen_q;
  logic                 par_q;
  logic                 stop_left_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 line_q;
  logic                 done_q;

  logic [DIV_WIDTH-1:0] div_clamped;
  logic [DIV_WIDTH-1:0] baud_div;
  logic                 idle;
  logic                 transfer;
  logic                 tick;

  assign idle        = (state_q == IDLE);
  assign div_clamped = (div_i < MIN_DIV_W) ? MIN_DIV_W : div_i;
  // The timer loads from the live input on the accepting edge, then the latched copy.
  assign baud_div    = idle ? div_clamped : div_q;
  assign transfer    = tx_valid_i && tx_ready_o;
  assign busy_o      = !idle;
  assign done_o      = done_q;

`ifdef UART_TX_BREAK_EN
  assign tx_ready_o = idle && !brk_i;
  assign uart_tx_o  = line_q && !(idle && brk_i && !rst_i);
`else
  assign tx_ready_o = idle;
  assign uart_tx_o  = line_q;
`endif

  uart_baud_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .restart_i(transfer),
    .div_i    (baud_div),
    .tick_o   (tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      wls_q       <= '0;
      stb_q       <= 1'b0;
      pen_q       <= 1'b0;
      par_q       <= 1'b0;
      stop_left_q <= 1'b0;
      div_q       <= '0;
      line_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          line_q <= 1'b1;
          if (transfer) begin
            shift_q <= tx_data_i;
            wls_q   <= wls_i;
            stb_q   <= stb_i;
            pen_q   <= pen_i;
            par_q   <= parity_bit(tx_data_i, wls_i, ps_i);
            div_q   <= div_clamped;
            line_q  <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            line_q    <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          // bit_cnt_q indexes the bit currently on the line; last index is 4+wls.
          if (tick) begin
            if (bit_cnt_q == {1'b1, wls_q}) begin
              if (pen_q) begin
                line_q  <= par_q;
                state_q <= PARITY;
              end else begin
                line_q      <= 1'b1;
                stop_left_q <= stb_q;
                state_q     <= STOP;
              end
            end else begin
              line_q    <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            line_q      <= 1'b1;
            stop_left_q <= stb_q;
            state_q     <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_left_q) begin
              stop_left_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: directed frames plus randomized frames
// compared cycle by cycle against a bit-list model of the serial frame.
module tb_uart_tx_core;

  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] div_i;
  logic [1:0]    wls_i;
  logic          stb_i;
  logic          pen_i;
  logic [1:0]    ps_i;
  logic          tx_valid_i;
  logic [7:0]    tx_data_i;
  logic          tx_ready_o;
  logic          uart_tx_o;
  logic          busy_o;
  logic          done_o;
`ifdef UART_TX_BREAK_EN
  logic          brk_i = 1'b0;
`endif

  int checks = 0;
  int passed = 0;

  uart_tx_core #(.DIV_WIDTH(DW)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .div_i     (div_i),
    .wls_i     (wls_i),
    .stb_i     (stb_i),
    .pen_i     (pen_i),
    .ps_i      (ps_i),
    .tx_valid_i(tx_valid_i),
    .tx_data_i (tx_data_i),
    .tx_ready_o(tx_ready_o),
    .uart_tx_o (uart_tx_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
`ifdef UART_TX_BREAK_EN
    ,
    .brk_i     (brk_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, need $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic scramble_inputs();
    tx_data_i = 8'($urandom);
    div_i     = DW'($urandom_range(0, 15));
    wls_i     = 2'($urandom_range(0, 3));
    stb_i     = 1'($urandom_range(0, 1));
    pen_i     = 1'($urandom_range(0, 1));
    ps_i      = 2'($urandom_range(0, 3));
  endtask

  // Starts a frame (must be called at a negedge in IDLE) and checks every cycle
  // of the line against the model; returns at the negedge of the IDLE cycle.
  task automatic run_frame(input logic [7:0] data, input logic [DW-1:0] div,
                           input logic [1:0] wls, input logic stb, input logic pen,
                           input logic [1:0] ps, input string name);
    bit exp_q[$];
    int d;
    int nb;
    int ones;
    logic [3:0] obs;
    d    = (div < 2) ? 2 : int'(div);
    nb   = 5 + int'(wls);
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (pen) begin
      case (ps)
        2'b00: exp_q.push_back((ones % 2) == 0);
        2'b01: exp_q.push_back((ones % 2) == 1);
        2'b10: exp_q.push_back(1'b1);
        default: exp_q.push_back(1'b0);
      endcase
    end
    exp_q.push_back(1'b1);
    if (stb) exp_q.push_back(1'b1);

    checks++;
    if (tx_ready_o !== 1'b1)
      $display("[TB] FAIL %s ready_before: got %b need 1", name, tx_ready_o);
    else passed++;
    tx_data_i = data; div_i = div; wls_i = wls; stb_i = stb; pen_i = pen; ps_i = ps;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    scramble_inputs();
    for (int b = 0; b < exp_q.size(); b++) begin
      for (int c = 0; c < d; c++) begin
        obs = {uart_tx_o, busy_o, tx_ready_o, done_o};
        checks++;
        if (obs !== {exp_q[b], 3'b100})
          $display("[TB] FAIL %s bit%0d cyc%0d {line,busy,ready,done}: got %b need %b",
                   name, b, c, obs, {exp_q[b], 3'b100});
        else passed++;
        @(negedge clk_i);
      end
    end
    obs = {uart_tx_o, busy_o, tx_ready_o, done_o};
    checks++;
    if (obs !== 4'b1011)
      $display("[TB] FAIL %s end_of_frame {line,busy,ready,done}: got %b need 1011", name, obs);
    else passed++;
  endtask

  // Starts a frame, counts cycles until done_o (bounded) and captures the line
  // at one chosen cycle (cycle 1 = first low cycle). len = -1 on timeout.
  task automatic probe(input logic [7:0] data, input logic [DW-1:0] div,
                       input logic [1:0] wls, input logic stb, input logic pen,
                       input logic [1:0] ps, input int at_cycle,
                       output int len, output logic bit_at);
    int cyc;
    tx_data_i = data; div_i = div; wls_i = wls; stb_i = stb; pen_i = pen; ps_i = ps;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    scramble_inputs();
    cyc = 1;
    bit_at = 1'bx;
    while (done_o !== 1'b1 && cyc < 1000) begin
      if (cyc == at_cycle) bit_at = uart_tx_o;
      @(negedge clk_i);
      cyc++;
    end
    len = (done_o === 1'b1) ? cyc - 1 : -1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst_i = 1'b1; tx_valid_i = 1'b0;
    tx_data_i = '0; div_i = '0; wls_i = '0; stb_i = 1'b0; pen_i = 1'b0; ps_i = '0;
    repeat (2) @(negedge clk_i);
    obs = {uart_tx_o, busy_o, tx_ready_o, done_o};
    checks++;
    if (obs !== 4'b1010) $display("[TB] FAIL reset_held: got %b need 1010", obs);
    else passed++;
    rst_i = 1'b0;
    @(negedge clk_i);
    obs = {uart_tx_o, busy_o, tx_ready_o, done_o};
    checks++;
    if (obs !== 4'b1010) $display("[TB] FAIL reset_released: got %b need 1010", obs);
    else passed++;
  endtask

  task automatic test_frame_55();
    int len;
    logic b;
    run_frame(8'h55, 16'd4, 2'b11, 1'b0, 1'b0, 2'b00, "8n1_55");
    probe(8'h55, 16'd4, 2'b11, 1'b0, 1'b0, 2'b00, 5, len, b);
    checks++;
    if (len !== 40) $display("[TB] FAIL 8n1_55_length: got %0d need 40", len);
    else passed++;
    checks++;
    if (b !== 1'b1) $display("[TB] FAIL 8n1_55_bit0: got %b need 1", b);
    else passed++;
  endtask

  task automatic test_parity();
    int len;
    logic b;
    run_frame(8'h07, 16'd2, 2'b11, 1'b0, 1'b1, 2'b01, "par_even");
    // Parity is bit 9 of the frame: cycles 19-20 at div=2.
    probe(8'h07, 16'd2, 2'b11, 1'b0, 1'b1, 2'b01, 19, len, b);
    checks++;
    if (b !== 1'b1) $display("[TB] FAIL par_even_bit: got %b need 1", b);
    else passed++;
    probe(8'h07, 16'd2, 2'b11, 1'b0, 1'b1, 2'b00, 19, len, b);
    checks++;
    if (b !== 1'b0) $display("[TB] FAIL par_odd_bit: got %b need 0", b);
    else passed++;
    probe(8'h07, 16'd2, 2'b11, 1'b0, 1'b1, 2'b10, 19, len, b);
    checks++;
    if (b !== 1'b1) $display("[TB] FAIL par_stick1_bit: got %b need 1", b);
    else passed++;
    checks++;
    if (len !== 22) $display("[TB] FAIL par_length: got %0d need 22", len);
    else passed++;
  endtask

  task automatic test_5bit_two_stop();
    int len;
    logic b;
    run_frame(8'hff, 16'd3, 2'b00, 1'b1, 1'b0, 2'b00, "5n2_ff");
    probe(8'hff, 16'd3, 2'b00, 1'b1, 1'b0, 2'b00, 1, len, b);
    checks++;
    if (len !== 24) $display("[TB] FAIL 5n2_length: got %0d need 24", len);
    else passed++;
  endtask

  task automatic test_divisor();
    int len;
    logic b;
    run_frame(8'h3c, 16'd0, 2'b11, 1'b0, 1'b0, 2'b00, "div0");
    probe(8'h3c, 16'd0, 2'b11, 1'b0, 1'b0, 2'b00, 1, len, b);
    checks++;
    if (len !== 20) $display("[TB] FAIL div0_length: got %0d need 20", len);
    else passed++;
    probe(8'h3c, 16'd1, 2'b11, 1'b0, 1'b0, 2'b00, 1, len, b);
    checks++;
    if (len !== 20) $display("[TB] FAIL div1_length: got %0d need 20", len);
    else passed++;
    // probe rewrites div_i mid-frame; the latched value must still govern.
    probe(8'h3c, 16'd3, 2'b11, 1'b0, 1'b0, 2'b00, 1, len, b);
    checks++;
    if (len !== 30) $display("[TB] FAIL div_change_length: got %0d need 30", len);
    else passed++;
  endtask

  task automatic test_back_to_back();
    run_frame(8'ha5, 16'd2, 2'b11, 1'b0, 1'b1, 2'b00, "b2b_0");
    run_frame(8'h0f, 16'd3, 2'b01, 1'b1, 1'b0, 2'b00, "b2b_1");
    run_frame(8'h80, 16'd2, 2'b10, 1'b0, 1'b1, 2'b11, "b2b_2");
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] obs;
    bit saw_done;
    bit saw_low;
    tx_data_i = 8'h00; div_i = 16'd4; wls_i = 2'b11; stb_i = 1'b0; pen_i = 1'b0; ps_i = 2'b00;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    checks++;
    if (uart_tx_o !== 1'b0) $display("[TB] FAIL rst_mid_data_low: got %b need 0", uart_tx_o);
    else passed++;
    rst_i = 1'b1;
    #1;
    obs = {uart_tx_o, busy_o, tx_ready_o, done_o};
    checks++;
    if (obs !== 4'b1010) $display("[TB] FAIL rst_mid_async: got %b need 1010", obs);
    else passed++;
    @(negedge clk_i);
    rst_i = 1'b0;
    saw_done = 1'b0;
    saw_low  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (done_o !== 1'b0) saw_done = 1'b1;
      if (uart_tx_o !== 1'b1) saw_low = 1'b1;
    end
    checks++;
    if (saw_done) $display("[TB] FAIL rst_mid_no_done: got pulse need none");
    else passed++;
    checks++;
    if (saw_low) $display("[TB] FAIL rst_mid_line_idle: got low need high");
    else passed++;
    checks++;
    if (tx_ready_o !== 1'b1) $display("[TB] FAIL rst_mid_ready: got %b need 1", tx_ready_o);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_frame(8'($urandom), DW'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk_i);
    end
  endtask

  initial begin
    test_reset();
    test_frame_55();
    test_parity();
    test_5bit_two_stop();
    test_divisor();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
